// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : PC sequencing, instruction memory read handshake and field split.
//            Optional macro FETCH_BRANCH_EN adds the branch offset to next_pc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        stall,
   output logic [31:0] imem_addr,
   output logic        imem_read,
   input  logic [31:0] imem_readdata,
   input  logic        imem_busy,
   input  logic        branch_taken,
   input  logic [7:0]  branch_offset,
   output logic [31:0] pc,
   output logic        instr_valid,
   output logic [7:0]  opcode,
   output logic [2:0]  dest,
   output logic [2:0]  src1,
   output logic [2:0]  src2,
   output logic [7:0]  immediate
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_run;
   logic [31:0] r_pc;
   logic        r_read;
   logic        r_valid;
   logic [7:0]  r_opcode;
   logic [2:0]  r_dest;
   logic [2:0]  r_src1;
   logic [2:0]  r_src2;
   logic [7:0]  r_imm;
   logic [31:0] w_next_pc;
   logic        w_unused;

`ifdef FETCH_BRANCH_EN
   logic [31:0] w_br_off;
   assign w_br_off  = {{22{branch_offset[7]}}, branch_offset, 2'b00};
   assign w_next_pc = r_pc + PC_STEP + (branch_taken ? w_br_off : 32'd0);
   assign w_unused  = &{1'b0, imem_readdata[23:19], imem_readdata[15:11]};
`else
   assign w_next_pc = r_pc + PC_STEP;
   assign w_unused  = &{1'b0, imem_readdata[23:19], imem_readdata[15:11],
                        branch_taken, branch_offset};
`endif

   // Release is retimed by one edge so IDLE spans a full clock cycle
   // no matter where within the cycle RESET is deasserted.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_read   <= 1'b0;
         r_valid  <= 1'b0;
         r_opcode <= 8'd0;
         r_dest   <= 3'd0;
         r_src1   <= 3'd0;
         r_src2   <= 3'd0;
         r_imm    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_run) begin
                  r_state <= S_FETCH;
                  r_read  <= 1'b1;
               end
            end
            S_FETCH: begin
               if (!imem_busy) begin
                  r_opcode <= imem_readdata[31:24];
                  r_dest   <= imem_readdata[18:16];
                  r_src1   <= imem_readdata[10:8];
                  r_src2   <= imem_readdata[2:0];
                  r_imm    <= imem_readdata[7:0];
                  r_read   <= 1'b0;
                  r_valid  <= 1'b1;
                  r_state  <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  r_pc    <= w_next_pc;
                  r_valid <= 1'b0;
                  r_read  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_read  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = r_pc;
   assign imem_addr   = r_pc;
   assign imem_read   = r_read;
   assign instr_valid = r_valid;
   assign opcode      = r_opcode;
   assign dest        = r_dest;
   assign src1        = r_src1;
   assign src2        = r_src2;
   assign immediate   = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed self-checking bench for instruction_fetch_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

   logic        CLK;
   logic        RESET;
   logic        stall;
   logic        imem_busy;
   logic        branch_taken;
   logic [7:0]  branch_offset;

   logic [31:0] addr0, pc0, rdata0;
   logic        read0, valid0;
   logic [7:0]  opc0, imm0;
   logic [2:0]  dest0, src10, src20;

   logic [31:0] addr1, pc1, rdata1;
   logic        read1, valid1;
   logic [7:0]  opc1, imm1;
   logic [2:0]  dest1, src11, src21;

   int n_checks;
   int n_pass;

   // Memory image: address 0 holds 0x01020304, elsewhere {addr[7:0],07,05,33}
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'd0) return 32'h01020304;
      return {a[7:0], 8'h07, 8'h05, 8'h33};
   endfunction

   assign rdata0 = memword(addr0);
   assign rdata1 = memword(addr1);

   instruction_fetch_unit u_dut (
      .CLK(CLK), .RESET(RESET), .stall(stall),
      .imem_addr(addr0), .imem_read(read0), .imem_readdata(rdata0),
      .imem_busy(imem_busy), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .pc(pc0), .instr_valid(valid0),
      .opcode(opc0), .dest(dest0), .src1(src10), .src2(src20),
      .immediate(imm0)
   );

   instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC), .PC_STEP(32'd4)) u_dut_wrap (
      .CLK(CLK), .RESET(RESET), .stall(stall),
      .imem_addr(addr1), .imem_read(read1), .imem_readdata(rdata1),
      .imem_busy(imem_busy), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .pc(pc1), .instr_valid(valid1),
      .opcode(opc1), .dest(dest1), .src1(src11), .src2(src21),
      .immediate(imm1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic test_reset;
      #2;
      n_checks++; if (read0 !== 1'b0) $display("FAIL reset_read got=%0h exp=0", read0); else n_pass++;
      n_checks++; if (valid0 !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", valid0); else n_pass++;
      n_checks++; if (pc0 !== 32'd0) $display("FAIL reset_pc got=%08h exp=00000000", pc0); else n_pass++;
      n_checks++; if ({opc0, dest0, src10, src20, imm0} !== 25'd0) $display("FAIL reset_fields got=%07h exp=0", {opc0, dest0, src10, src20, imm0}); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (read0 !== 1'b0) $display("FAIL reset_hold_read got=%0h exp=0", read0); else n_pass++;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_first_fetch;
      @(posedge CLK); #1;
      n_checks++; if (read0 !== 1'b0) $display("FAIL ff_edge1_read got=%0h exp=0", read0); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (read0 !== 1'b1) $display("FAIL ff_edge2_read got=%0h exp=1", read0); else n_pass++;
      n_checks++; if (valid0 !== 1'b0) $display("FAIL ff_edge2_valid got=%0h exp=0", valid0); else n_pass++;
      n_checks++; if (addr0 !== 32'd0) $display("FAIL ff_addr got=%08h exp=00000000", addr0); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (valid0 !== 1'b1) $display("FAIL ff_valid got=%0h exp=1", valid0); else n_pass++;
      n_checks++; if (read0 !== 1'b0) $display("FAIL ff_hold_read got=%0h exp=0", read0); else n_pass++;
      n_checks++; if (opc0 !== 8'h01) $display("FAIL ff_opcode got=%02h exp=01", opc0); else n_pass++;
      n_checks++; if (dest0 !== 3'd2) $display("FAIL ff_dest got=%0d exp=2", dest0); else n_pass++;
      n_checks++; if (src10 !== 3'd3) $display("FAIL ff_src1 got=%0d exp=3", src10); else n_pass++;
      n_checks++; if (src20 !== 3'd4) $display("FAIL ff_src2 got=%0d exp=4", src20); else n_pass++;
      n_checks++; if (imm0 !== 8'h04) $display("FAIL ff_imm got=%02h exp=04", imm0); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (pc0 !== 32'd4) $display("FAIL ff_next_pc got=%08h exp=00000004", pc0); else n_pass++;
      n_checks++; if (read0 !== 1'b1) $display("FAIL ff_next_read got=%0h exp=1", read0); else n_pass++;
      n_checks++; if (valid0 !== 1'b0) $display("FAIL ff_next_valid got=%0h exp=0", valid0); else n_pass++;
   endtask

   task automatic test_busy;
      @(posedge CLK); #1;
      n_checks++; if (opc0 !== 8'h04) $display("FAIL busy_pc4_opcode got=%02h exp=04", opc0); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (pc0 !== 32'd8) $display("FAIL busy_pc got=%08h exp=00000008", pc0); else n_pass++;
      imem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         n_checks++; if ({read0, valid0} !== 2'b10) $display("FAIL busy_wait%0d read_valid got=%02b exp=10", i, {read0, valid0}); else n_pass++;
         n_checks++; if (pc0 !== 32'd8) $display("FAIL busy_wait%0d pc got=%08h exp=00000008", i, pc0); else n_pass++;
      end
      imem_busy = 1'b0;
      @(posedge CLK); #1;
      n_checks++; if (valid0 !== 1'b1) $display("FAIL busy_done_valid got=%0h exp=1", valid0); else n_pass++;
      n_checks++; if ({opc0, dest0, src10, src20, imm0} !== {8'h08, 3'd7, 3'd5, 3'd3, 8'h33}) $display("FAIL busy_fields got=%07h exp=%07h", {opc0, dest0, src10, src20, imm0}, {8'h08, 3'd7, 3'd5, 3'd3, 8'h33}); else n_pass++;
   endtask

   task automatic test_stall_branch;
      logic [31:0] exp_pc;
`ifdef FETCH_BRANCH_EN
      exp_pc = 32'h1C;
`else
      exp_pc = 32'h14;
`endif
      repeat (3) @(posedge CLK);
      #1;
      n_checks++; if (pc0 !== 32'h10) $display("FAIL stall_setup_pc got=%08h exp=00000010", pc0); else n_pass++;
      stall = 1'b1;
      branch_taken = 1'b1;
      branch_offset = 8'h02;
      @(posedge CLK); #1;
      n_checks++; if (valid0 !== 1'b1) $display("FAIL stall_fetch_completes valid got=%0h exp=1", valid0); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         n_checks++; if (pc0 !== 32'h10) $display("FAIL stall%0d_pc got=%08h exp=00000010", i, pc0); else n_pass++;
         n_checks++; if ({valid0, read0, opc0} !== {2'b10, 8'h10}) $display("FAIL stall%0d_state got=%03h exp=210", i, {valid0, read0, opc0}); else n_pass++;
      end
      stall = 1'b0;
      @(posedge CLK); #1;
      n_checks++; if (pc0 !== exp_pc) $display("FAIL branch_pc got=%08h exp=%08h", pc0, exp_pc); else n_pass++;
      n_checks++; if (read0 !== 1'b1) $display("FAIL branch_read got=%0h exp=1", read0); else n_pass++;
      branch_taken = 1'b0;
      branch_offset = 8'h00;
   endtask

   task automatic test_wrap;
      RESET = 1'b0;
      #1;
      n_checks++; if (pc1 !== 32'hFFFFFFFC) $display("FAIL wrap_reset_pc got=%08h exp=FFFFFFFC", pc1); else n_pass++;
      n_checks++; if (pc0 !== 32'd0) $display("FAIL wrap_reset_pc0 got=%08h exp=00000000", pc0); else n_pass++;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      n_checks++; if ({read1, addr1} !== {1'b1, 32'hFFFFFFFC}) $display("FAIL wrap_fetch got=%09h exp=1FFFFFFFC", {read1, addr1}); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if ({valid1, opc1} !== {1'b1, 8'hFC}) $display("FAIL wrap_hold got=%03h exp=1FC", {valid1, opc1}); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if (pc1 !== 32'd0) $display("FAIL wrap_pc got=%08h exp=00000000", pc1); else n_pass++;
      n_checks++; if (addr1 !== 32'd0) $display("FAIL wrap_addr got=%08h exp=00000000", addr1); else n_pass++;
   endtask

   task automatic test_reset_mid_fetch;
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      imem_busy = 1'b1;
      @(posedge CLK); #1;
      n_checks++; if ({read0, pc0} !== {1'b1, 32'd4}) $display("FAIL rmf_fetch got=%09h exp=100000004", {read0, pc0}); else n_pass++;
      @(posedge CLK); #1;
      #2;
      RESET = 1'b0;
      #1;
      n_checks++; if (read0 !== 1'b0) $display("FAIL rmf_async_read got=%0h exp=0", read0); else n_pass++;
      n_checks++; if (valid0 !== 1'b0) $display("FAIL rmf_async_valid got=%0h exp=0", valid0); else n_pass++;
      n_checks++; if (pc0 !== 32'd0) $display("FAIL rmf_async_pc got=%08h exp=00000000", pc0); else n_pass++;
      n_checks++; if (opc0 !== 8'h00) $display("FAIL rmf_async_opcode got=%02h exp=00", opc0); else n_pass++;
      imem_busy = 1'b0;
      @(posedge CLK); #1;
      n_checks++; if ({read0, valid0, opc0} !== 10'd0) $display("FAIL rmf_late_resp got=%03h exp=000", {read0, valid0, opc0}); else n_pass++;
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK); #1;
      n_checks++; if (read0 !== 1'b0) $display("FAIL rmf_idle_read got=%0h exp=0", read0); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if ({read0, pc0} !== {1'b1, 32'd0}) $display("FAIL rmf_restart got=%09h exp=100000000", {read0, pc0}); else n_pass++;
      @(posedge CLK); #1;
      n_checks++; if ({valid0, opc0} !== {1'b1, 8'h01}) $display("FAIL rmf_resume got=%03h exp=101", {valid0, opc0}); else n_pass++;
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      RESET         = 1'b0;
      stall         = 1'b0;
      imem_busy     = 1'b0;
      branch_taken  = 1'b0;
      branch_offset = 8'h00;
      test_reset();
      test_first_fetch();
      test_busy();
      test_stall_branch();
      test_wrap();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
